tlul_host_arbiter: RTL and testbench

N-to-1 TileLink-UL host arbiter that shares one TL-UL device port, such as the address-decoding RAM/default-responder fabric, between NUM_HOSTS requesters. The A channel is arbitrated round-robin. The grant is held stable until the handshake completes. The host index is prepended to a_source so that D responses route back to the issuing host. A per-host outstanding counter throttles each host to MAX_OUTSTANDING in-flight requests.

---
 rtl/tlul_pkg.sv | 43 ++++
 rtl/tlul_rr_arb.sv | 34 +++
 rtl/tlul_host_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_tlul_host_arbiter.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlul_pkg.sv
// Shared TL-UL definitions for the host arbiter slice.
// Holds field widths, opcode constants, bundle typedefs and the arbiter state type.
package tlul_pkg;

    localparam int TL_AW  = 32;
    localparam int TL_DW  = 32;
    localparam int TL_AIW = 8;
    localparam int TL_DIW = 1;
    localparam int TL_DBW = TL_DW >> 3;
    localparam int TL_SZW = $clog2($clog2(TL_DBW) + 1);

    localparam logic [2:0] A_PUT_FULL      = 3'd0;
    localparam logic [2:0] A_PUT_PARTIAL   = 3'd1;
    localparam logic [2:0] A_GET           = 3'd4;
    localparam logic [2:0] D_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] D_ACCESS_ACK_DATA = 3'd1;

    typedef struct packed {
        logic [2:0]        opcode;
        logic [2:0]        param;
        logic [TL_SZW-1:0] size;
        logic [TL_AIW-1:0] source;
        logic [TL_AW-1:0]  address;
        logic [TL_DBW-1:0] mask;
        logic [TL_DW-1:0]  data;
    } tl_a_t;

    typedef struct packed {
        logic [2:0]        opcode;
        logic [2:0]        param;
        logic [TL_SZW-1:0] size;
        logic [TL_AIW-1:0] source;
        logic [TL_DIW-1:0] sink;
        logic [TL_DW-1:0]  data;
        logic              error;
    } tl_d_t;

    typedef enum logic {
        ARB_UNLOCKED = 1'b0,
        ARB_LOCKED   = 1'b1
    } arb_state_e;

endpackage

// File: rtl/tlul_rr_arb.sv
// Combinational round-robin picker: first set request at or after ptr, cyclically.
// Ports: req (request vector), ptr (search start), gnt (one-hot grant), idx (grant index).
module tlul_rr_arb
    import tlul_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    int   j;
    logic found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (!found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/tlul_host_arbiter.sv
// N-to-1 TL-UL host arbiter: round-robin A channel with grant lock, source tagging,
// per-host outstanding throttling and D routing by the tagged host index.
// Ports: clk/rstn, h_a_* / h_d_* per-host channels, dev_a_* / dev_d_* device channels,
// err_bad_source (sticky: D beat with an out-of-range host index).
module tlul_host_arbiter
    import tlul_pkg::*;
#(
    parameter int NUM_HOSTS       = 2,
    parameter int TL_AW           = 32,
    parameter int TL_DW           = 32,
    parameter int TL_AIW          = 8,
    parameter int TL_DIW          = 1,
    parameter int TL_DBW          = TL_DW >> 3,
    parameter int TL_SZW          = $clog2($clog2(TL_DBW) + 1),
    parameter int MAX_OUTSTANDING = 4,
    localparam int HIW            = $clog2(NUM_HOSTS)
) (
    input  logic                                 clk,
    input  logic                                 rstn,
    input  logic [NUM_HOSTS-1:0]                 h_a_valid,
    output logic [NUM_HOSTS-1:0]                 h_a_ready,
    input  logic [NUM_HOSTS-1:0][2:0]            h_a_opcode,
    input  logic [NUM_HOSTS-1:0][2:0]            h_a_param,
    input  logic [NUM_HOSTS-1:0][TL_SZW-1:0]     h_a_size,
    input  logic [NUM_HOSTS-1:0][TL_AIW-1:0]     h_a_source,
    input  logic [NUM_HOSTS-1:0][TL_AW-1:0]      h_a_address,
    input  logic [NUM_HOSTS-1:0][TL_DBW-1:0]     h_a_mask,
    input  logic [NUM_HOSTS-1:0][TL_DW-1:0]      h_a_data,
    output logic [NUM_HOSTS-1:0]                 h_d_valid,
    input  logic [NUM_HOSTS-1:0]                 h_d_ready,
    output logic [2:0]                           h_d_opcode,
    output logic [2:0]                           h_d_param,
    output logic [TL_SZW-1:0]                    h_d_size,
    output logic [TL_AIW-1:0]                    h_d_source,
    output logic [TL_DIW-1:0]                    h_d_sink,
    output logic [TL_DW-1:0]                     h_d_data,
    output logic                                 h_d_error,
    output logic                                 dev_a_valid,
    input  logic                                 dev_a_ready,
    output logic [2:0]                           dev_a_opcode,
    output logic [2:0]                           dev_a_param,
    output logic [TL_SZW-1:0]                    dev_a_size,
    output logic [TL_AIW+HIW-1:0]                dev_a_source,
    output logic [TL_AW-1:0]                     dev_a_address,
    output logic [TL_DBW-1:0]                    dev_a_mask,
    output logic [TL_DW-1:0]                     dev_a_data,
    input  logic                                 dev_d_valid,
    output logic                                 dev_d_ready,
    input  logic [2:0]                           dev_d_opcode,
    input  logic [2:0]                           dev_d_param,
    input  logic [TL_SZW-1:0]                    dev_d_size,
    input  logic [TL_AIW+HIW-1:0]                dev_d_source,
    input  logic [TL_DIW-1:0]                    dev_d_sink,
    input  logic [TL_DW-1:0]                     dev_d_data,
    input  logic                                 dev_d_error,
    output logic                                 err_bad_source
);

    arb_state_e                  state;
    logic [HIW-1:0]              rr_ptr;
    logic [HIW-1:0]              lock_host;
    logic [NUM_HOSTS-1:0][3:0]   cnt;

    logic [NUM_HOSTS-1:0]        elig;
    logic [NUM_HOSTS-1:0]        gnt;
    logic [NUM_HOSTS-1:0]        own;
    logic [NUM_HOSTS-1:0]        d_sel;
    logic [NUM_HOSTS-1:0]        a_fire;
    logic [NUM_HOSTS-1:0]        d_fire;
    logic [HIW-1:0]              arb_idx;
    logic [HIW-1:0]              sel;
    logic [HIW-1:0]              d_idx;
    logic                        sel_ok;
    logic                        d_bad;

    function automatic logic [HIW-1:0] inc_ptr(input logic [HIW-1:0] p);
        return (p == HIW'(NUM_HOSTS - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_HOSTS; i++) begin
            elig[i] = h_a_valid[i] & (cnt[i] < 4'(MAX_OUTSTANDING));
        end
    end

    tlul_rr_arb #(
        .N  (NUM_HOSTS),
        .IW (HIW)
    ) u_rr_arb (
        .req (elig),
        .ptr (rr_ptr),
        .gnt (gnt),
        .idx (arb_idx)
    );

    // While locked only the held host may present, so the beat stays stable.
    always_comb begin
        for (int i = 0; i < NUM_HOSTS; i++) begin
            if (state == ARB_LOCKED)
                own[i] = elig[i] & (lock_host == HIW'(i));
            else
                own[i] = gnt[i];
        end
    end

    assign sel       = (state == ARB_LOCKED) ? lock_host : arb_idx;
    assign sel_ok    = |own;
    assign h_a_ready = own & {NUM_HOSTS{dev_a_ready}};
    assign a_fire    = h_a_valid & h_a_ready;

    assign dev_a_valid   = sel_ok;
    assign dev_a_opcode  = sel_ok ? h_a_opcode[sel]  : '0;
    assign dev_a_param   = sel_ok ? h_a_param[sel]   : '0;
    assign dev_a_size    = sel_ok ? h_a_size[sel]    : '0;
    assign dev_a_source  = sel_ok ? {sel, h_a_source[sel]} : '0;
    assign dev_a_address = sel_ok ? h_a_address[sel] : '0;
    assign dev_a_mask    = sel_ok ? h_a_mask[sel]    : '0;
    assign dev_a_data    = sel_ok ? h_a_data[sel]    : '0;

    assign d_idx = dev_d_source[TL_AIW+HIW-1:TL_AIW];
    assign d_bad = 32'(d_idx) >= NUM_HOSTS;

    always_comb begin
        for (int i = 0; i < NUM_HOSTS; i++) begin
            d_sel[i] = ~d_bad & (d_idx == HIW'(i));
        end
    end

    // Out-of-range beats are swallowed so the device never stalls on them.
    assign dev_d_ready = d_bad | (|(d_sel & h_d_ready));
    assign h_d_valid   = d_sel & {NUM_HOSTS{dev_d_valid}};
    assign d_fire      = h_d_valid & h_d_ready;

    assign h_d_opcode = dev_d_opcode;
    assign h_d_param  = dev_d_param;
    assign h_d_size   = dev_d_size;
    assign h_d_source = dev_d_source[TL_AIW-1:0];
    assign h_d_sink   = dev_d_sink;
    assign h_d_data   = dev_d_data;
    assign h_d_error  = dev_d_error;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= ARB_UNLOCKED;
            rr_ptr    <= '0;
            lock_host <= '0;
        end else begin
            unique case (state)
                ARB_UNLOCKED: begin
                    if (sel_ok) begin
                        if (dev_a_ready) begin
                            rr_ptr <= inc_ptr(arb_idx);
                        end else begin
                            state     <= ARB_LOCKED;
                            lock_host <= arb_idx;
                        end
                    end
                end
                ARB_LOCKED: begin
                    if (sel_ok && dev_a_ready) begin
                        rr_ptr <= inc_ptr(lock_host);
                        state  <= ARB_UNLOCKED;
                    end
                end
                default: state <= ARB_UNLOCKED;
            endcase
        end
    end

    // Decrement at zero is a spurious response and saturates.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_HOSTS; i++) begin
                if (a_fire[i] && !d_fire[i])
                    cnt[i] <= cnt[i] + 4'd1;
                else if (d_fire[i] && !a_fire[i] && cnt[i] != 4'd0)
                    cnt[i] <= cnt[i] - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            err_bad_source <= 1'b0;
        else if (dev_d_valid && d_bad)
            err_bad_source <= 1'b1;
    end

endmodule

// File: tb/tb_tlul_host_arbiter.sv
// Testbench for tlul_host_arbiter with three hosts: vector table, directed
// multi-cycle sequences and randomized traffic against a reference model.
module tb_tlul_host_arbiter;
    import tlul_pkg::*;

    localparam int N = 3;

    logic             clk;
    logic             rstn;
    logic [N-1:0]     h_a_valid, h_a_ready;
    logic [N-1:0][2:0]  h_a_opcode, h_a_param;
    logic [N-1:0][1:0]  h_a_size;
    logic [N-1:0][7:0]  h_a_source;
    logic [N-1:0][31:0] h_a_address;
    logic [N-1:0][3:0]  h_a_mask;
    logic [N-1:0][31:0] h_a_data;
    logic [N-1:0]     h_d_valid, h_d_ready;
    logic [2:0]       h_d_opcode, h_d_param;
    logic [1:0]       h_d_size;
    logic [7:0]       h_d_source;
    logic [0:0]       h_d_sink;
    logic [31:0]      h_d_data;
    logic             h_d_error;
    logic             dev_a_valid, dev_a_ready;
    logic [2:0]       dev_a_opcode, dev_a_param;
    logic [1:0]       dev_a_size;
    logic [9:0]       dev_a_source;
    logic [31:0]      dev_a_address;
    logic [3:0]       dev_a_mask;
    logic [31:0]      dev_a_data;
    logic             dev_d_valid, dev_d_ready;
    logic [2:0]       dev_d_opcode, dev_d_param;
    logic [1:0]       dev_d_size;
    logic [9:0]       dev_d_source;
    logic [0:0]       dev_d_sink;
    logic [31:0]      dev_d_data;
    logic             dev_d_error;
    logic             err_bad_source;

    int n_vec = 0;
    int n_bad = 0;

    tlul_host_arbiter #(.NUM_HOSTS(N), .MAX_OUTSTANDING(4)) dut (
        .clk(clk), .rstn(rstn),
        .h_a_valid(h_a_valid), .h_a_ready(h_a_ready),
        .h_a_opcode(h_a_opcode), .h_a_param(h_a_param), .h_a_size(h_a_size),
        .h_a_source(h_a_source), .h_a_address(h_a_address),
        .h_a_mask(h_a_mask), .h_a_data(h_a_data),
        .h_d_valid(h_d_valid), .h_d_ready(h_d_ready),
        .h_d_opcode(h_d_opcode), .h_d_param(h_d_param), .h_d_size(h_d_size),
        .h_d_source(h_d_source), .h_d_sink(h_d_sink), .h_d_data(h_d_data),
        .h_d_error(h_d_error),
        .dev_a_valid(dev_a_valid), .dev_a_ready(dev_a_ready),
        .dev_a_opcode(dev_a_opcode), .dev_a_param(dev_a_param),
        .dev_a_size(dev_a_size), .dev_a_source(dev_a_source),
        .dev_a_address(dev_a_address), .dev_a_mask(dev_a_mask),
        .dev_a_data(dev_a_data),
        .dev_d_valid(dev_d_valid), .dev_d_ready(dev_d_ready),
        .dev_d_opcode(dev_d_opcode), .dev_d_param(dev_d_param),
        .dev_d_size(dev_d_size), .dev_d_source(dev_d_source),
        .dev_d_sink(dev_d_sink), .dev_d_data(dev_d_data),
        .dev_d_error(dev_d_error),
        .err_bad_source(err_bad_source)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic idle();
        h_a_valid = '0; h_a_opcode = '0; h_a_param = '0; h_a_size = '0;
        h_a_source = '0; h_a_address = '0; h_a_mask = '0; h_a_data = '0;
        h_d_ready = '0; dev_a_ready = 1'b0;
        dev_d_valid = 1'b0; dev_d_opcode = '0; dev_d_param = '0;
        dev_d_size = '0; dev_d_source = '0; dev_d_sink = '0;
        dev_d_data = '0; dev_d_error = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        idle();
        @(negedge clk);
        rstn = 1'b1;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [2:0] hv;
        logic       ar;
        logic       dv;
        logic [9:0] dsrc;
        logic [2:0] hdr;
        logic [2:0] e_har;
        logic       e_av;
        logic [1:0] e_idx;
        logic [2:0] e_hdv;
        logic       e_ddr;
    } vec_t;

    vec_t tbl[6];

    // reference model state
    int        m_cnt[N];
    int        m_rr;
    bit        m_locked;
    int        m_lock;
    bit        m_err;
    bit        hv[N];
    logic [7:0]  hsrc[N];
    logic [31:0] haddr[N];
    int        dq[$];
    bit        d_drv, d_isbad, ar;
    logic [9:0] d_src;
    logic [2:0] hdr;

    initial begin
        rstn = 1'b0;
        idle();

        tbl[0] = '{3'b000, 1'b1, 1'b0, 10'h000, 3'b000, 3'b000, 1'b0, 2'd0, 3'b000, 1'b0};
        tbl[1] = '{3'b110, 1'b1, 1'b0, 10'h000, 3'b000, 3'b010, 1'b1, 2'd1, 3'b000, 1'b0};
        tbl[2] = '{3'b100, 1'b0, 1'b0, 10'h000, 3'b000, 3'b000, 1'b1, 2'd2, 3'b000, 1'b0};
        tbl[3] = '{3'b111, 1'b1, 1'b1, 10'h205, 3'b100, 3'b001, 1'b1, 2'd0, 3'b100, 1'b1};
        tbl[4] = '{3'b000, 1'b0, 1'b1, 10'h300, 3'b000, 3'b000, 1'b0, 2'd0, 3'b000, 1'b1};
        tbl[5] = '{3'b000, 1'b0, 1'b1, 10'h011, 3'b110, 3'b000, 1'b0, 2'd0, 3'b001, 1'b0};

        // reset state with idle inputs
        #2;
        chk("rst_av", dev_a_valid, 1'b0);
        chk("rst_har", h_a_ready, 3'b000);
        chk("rst_hdv", h_d_valid, 3'b000);
        chk("rst_err", err_bad_source, 1'b0);

        foreach (tbl[r]) begin
            do_reset();
            h_a_valid = tbl[r].hv;
            for (int i = 0; i < N; i++) h_a_source[i] = 8'(8'h40 + i);
            dev_a_ready = tbl[r].ar;
            dev_d_valid = tbl[r].dv;
            dev_d_source = tbl[r].dsrc;
            h_d_ready = tbl[r].hdr;
            #1;
            chk($sformatf("tbl%0d_har", r), h_a_ready, tbl[r].e_har);
            chk($sformatf("tbl%0d_av", r), dev_a_valid, tbl[r].e_av);
            chk($sformatf("tbl%0d_src", r), dev_a_source,
                tbl[r].e_av ? {tbl[r].e_idx, 8'(8'h40 + tbl[r].e_idx)} : 10'h0);
            chk($sformatf("tbl%0d_hdv", r), h_d_valid, tbl[r].e_hdv);
            chk($sformatf("tbl%0d_ddr", r), dev_d_ready, tbl[r].e_ddr);
        end

        // round robin with ready held high
        do_reset();
        h_a_valid = 3'b011;
        h_a_opcode[0] = A_GET; h_a_opcode[1] = A_GET;
        h_a_address[0] = 32'h100; h_a_address[1] = 32'h100;
        h_a_source[0] = 8'h11; h_a_source[1] = 8'h22;
        dev_a_ready = 1'b1;
        #1;
        chk("rr_first_idx", dev_a_source, 10'h011);
        chk("rr_first_har", h_a_ready, 3'b001);
        chk("rr_first_op", dev_a_opcode, A_GET);
        step();
        h_a_valid = 3'b010;
        #1;
        chk("rr_second_idx", dev_a_source, 10'h122);
        chk("rr_second_har", h_a_ready, 3'b010);
        step();
        idle();

        // lock holds host 1 across a stalled device
        do_reset();
        h_a_valid = 3'b010;
        h_a_address[1] = 32'h200; h_a_source[1] = 8'h07;
        #1;
        chk("lock_c1_idx", dev_a_source[9:8], 2'd1);
        chk("lock_c1_har", h_a_ready, 3'b000);
        step();
        h_a_valid = 3'b011;
        h_a_address[0] = 32'h300;
        for (int c = 0; c < 2; c++) begin
            #1;
            chk("lock_hold_idx", dev_a_source[9:8], 2'd1);
            chk("lock_hold_addr", dev_a_address, 32'h200);
            step();
        end
        dev_a_ready = 1'b1;
        #1;
        chk("lock_rel_har", h_a_ready, 3'b010);
        step();
        h_a_valid = 3'b001;
        #1;
        chk("lock_next_idx", dev_a_source[9:8], 2'd0);
        chk("lock_next_addr", dev_a_address, 32'h300);
        chk("lock_next_har", h_a_ready, 3'b001);
        step();
        idle();

        // outstanding limit
        do_reset();
        h_a_valid = 3'b001;
        dev_a_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("lim_acc_har", h_a_ready, 3'b001);
            step();
        end
        #1;
        chk("lim_block_har", h_a_ready, 3'b000);
        chk("lim_block_av", dev_a_valid, 1'b0);
        dev_d_valid = 1'b1; dev_d_source = 10'h000; h_d_ready = 3'b001;
        #1;
        chk("lim_d_ddr", dev_d_ready, 1'b1);
        chk("lim_d_hdv", h_d_valid, 3'b001);
        chk("lim_d_har", h_a_ready, 3'b000);
        step();
        dev_d_valid = 1'b0;
        #1;
        chk("lim_free_har", h_a_ready, 3'b001);
        step();
        idle();

        // D routing with host back-pressure
        do_reset();
        dev_d_valid = 1'b1; dev_d_source = 10'h1AB; h_d_ready = 3'b000;
        for (int c = 0; c < 2; c++) begin
            #1;
            chk("dr_hdv", h_d_valid, 3'b010);
            chk("dr_src", h_d_source, 8'hAB);
            chk("dr_ddr_lo", dev_d_ready, 1'b0);
            step();
        end
        h_d_ready = 3'b010;
        #1;
        chk("dr_ddr_hi", dev_d_ready, 1'b1);
        step();
        idle();

        // simultaneous A and D acceptance at cnt = 2
        do_reset();
        h_a_valid = 3'b001;
        dev_a_ready = 1'b1;
        step();
        step();
        dev_d_valid = 1'b1; dev_d_source = 10'h000; h_d_ready = 3'b001;
        #1;
        chk("sim_har", h_a_ready, 3'b001);
        chk("sim_ddr", dev_d_ready, 1'b1);
        step();
        dev_d_valid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #1;
            chk("sim_more_har", h_a_ready, 3'b001);
            step();
        end
        #1;
        chk("sim_full_har", h_a_ready, 3'b000);
        step();
        idle();

        // bad host index
        do_reset();
        dev_d_valid = 1'b1; dev_d_source = 10'h355; h_d_ready = 3'b111;
        #1;
        chk("bad_hdv", h_d_valid, 3'b000);
        chk("bad_ddr", dev_d_ready, 1'b1);
        chk("bad_err_pre", err_bad_source, 1'b0);
        step();
        dev_d_valid = 1'b0;
        #1;
        chk("bad_err_set", err_bad_source, 1'b1);
        step();
        #1;
        chk("bad_err_sticky", err_bad_source, 1'b1);

        // reset while locked with host 1 at cnt 3
        do_reset();
        h_a_valid = 3'b010;
        dev_a_ready = 1'b1;
        step(); step(); step();
        dev_a_ready = 1'b0;
        step();
        #1;
        chk("mr_locked_av", dev_a_valid, 1'b1);
        rstn = 1'b0;
        idle();
        #1;
        chk("mr_av", dev_a_valid, 1'b0);
        chk("mr_har", h_a_ready, 3'b000);
        chk("mr_hdv", h_d_valid, 3'b000);
        chk("mr_err", err_bad_source, 1'b0);
        rstn = 1'b1;
        h_a_valid = 3'b111;
        dev_a_ready = 1'b1;
        #1;
        chk("mr_ptr_har", h_a_ready, 3'b001);
        step();
        h_a_valid = 3'b010;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("mr_cnt_har", h_a_ready, 3'b010);
            step();
        end
        #1;
        chk("mr_cnt_full", h_a_ready, 3'b000);
        idle();

        // randomized traffic against the model
        do_reset();
        for (int i = 0; i < N; i++) begin
            m_cnt[i] = 0; hv[i] = 0; hsrc[i] = '0; haddr[i] = '0;
        end
        m_rr = 0; m_locked = 0; m_lock = 0; m_err = 0;
        dq.delete();
        d_drv = 0; d_isbad = 0; d_src = '0; ar = 0; hdr = '0;
        step();

        for (int cyc = 0; cyc < 2000; cyc++) begin
            bit el[N];
            int win, di;
            bit bad, e_ddr, a_fire, d_fire;
            logic [2:0] e_har, e_hdv;

            for (int i = 0; i < N; i++) begin
                h_a_valid[i] = hv[i];
                h_a_source[i] = hsrc[i];
                h_a_address[i] = haddr[i];
                h_a_opcode[i] = A_GET;
            end
            dev_a_ready = ar;
            dev_d_valid = d_drv;
            dev_d_source = d_src;
            h_d_ready = hdr;

            for (int i = 0; i < N; i++) el[i] = hv[i] && m_cnt[i] < 4;
            win = -1;
            if (m_locked) begin
                if (el[m_lock]) win = m_lock;
            end else begin
                for (int k = 0; k < N; k++) begin
                    int j;
                    j = (m_rr + k) % N;
                    if (win < 0 && el[j]) win = j;
                end
            end
            e_har = '0;
            if (ar && win >= 0) e_har[win] = 1'b1;
            di = int'(d_src) / 256;
            bad = di >= N;
            e_hdv = '0;
            if (d_drv && !bad) e_hdv[di] = 1'b1;
            e_ddr = bad ? 1'b1 : hdr[di];

            @(negedge clk);
            chk("rnd_av", dev_a_valid, win >= 0);
            chk("rnd_asrc", dev_a_source, win >= 0 ? 10'(win * 256 + int'(hsrc[win])) : 10'h0);
            chk("rnd_aaddr", dev_a_address, win >= 0 ? haddr[win] : 32'h0);
            chk("rnd_har", h_a_ready, e_har);
            chk("rnd_hdv", h_d_valid, e_hdv);
            chk("rnd_ddr", dev_d_ready, e_ddr);
            chk("rnd_hdsrc", h_d_source, d_src[7:0]);
            chk("rnd_err", err_bad_source, m_err);
            step();

            a_fire = ar && win >= 0;
            d_fire = d_drv && e_ddr;
            if (a_fire) begin
                dq.push_back(win * 256 + int'(hsrc[win]));
                m_cnt[win]++;
                m_rr = (win + 1) % N;
                m_locked = 0;
                hv[win] = 0;
            end else if (win >= 0 && !m_locked) begin
                m_locked = 1;
                m_lock = win;
            end
            if (d_drv && bad) m_err = 1;
            if (d_fire) begin
                if (!bad && m_cnt[di] > 0) m_cnt[di]--;
                if (!d_isbad) void'(dq.pop_front());
                d_drv = 0;
                d_isbad = 0;
            end

            for (int i = 0; i < N; i++) begin
                if (!hv[i] && ($urandom % 2) == 0) begin
                    hv[i] = 1;
                    hsrc[i] = 8'($urandom);
                    haddr[i] = $urandom;
                end
            end
            ar = ($urandom % 3) != 0;
            hdr = 3'($urandom);
            if (!d_drv) begin
                if (dq.size() > 0 && ($urandom % 2) == 0) begin
                    d_drv = 1;
                    d_src = 10'(dq[0]);
                end else if (($urandom % 16) == 0) begin
                    d_drv = 1;
                    d_isbad = 1;
                    d_src = 10'(10'h300 | 10'($urandom % 256));
                end else begin
                    d_src = 10'($urandom % 1024);
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
